// File: rtl/quad_step_gen.sv
// Quadrature step generator: emits a Gray-coded A/B phase sequence, one phase
// change per step, for a loaded step count, direction and step period.
module quad_step_gen #(
   parameter int N     = 8,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Load,
   input  logic             Din,
   input  logic [N-1:0]     In,
   input  logic [DIV_W-1:0] Period,
   input  logic             En,
   input  logic             Abort,
   output logic             A,
   output logic             B,
   output logic             Step,
   output logic             Dir,
   output logic             Busy,
   output logic             Done,
   output logic [N-1:0]     Remaining
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic [DIV_W-1:0] timer_q, timer_d;
   logic [DIV_W-1:0] period_q, period_d;
   logic [N-1:0]     rem_q, rem_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             done_q, done_d;
   logic [DIV_W-1:0] period_eff;

   // Gray sequence 00 -> 01 -> 11 -> 10 going up; reversed going down.
   function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic up);
      logic [1:0] nx;
      case (ph)
         2'b00:   nx = up ? 2'b01 : 2'b10;
         2'b01:   nx = up ? 2'b11 : 2'b00;
         2'b11:   nx = up ? 2'b10 : 2'b01;
         default: nx = up ? 2'b00 : 2'b11;
      endcase
      return nx;
   endfunction

   assign period_eff = (Period == '0) ? DIV_W'(1) : Period;

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      timer_d  = timer_q;
      period_d = period_q;
      rem_d    = rem_q;
      dir_d    = dir_q;
      step_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (Load) begin
               if (In != '0) begin
                  rem_d    = In;
                  dir_d    = Din;
                  period_d = period_eff;
                  timer_d  = period_eff - DIV_W'(1);
                  state_d  = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            // Abort wins over a step falling due on the same edge.
            if (Abort) begin
               rem_d   = '0;
               state_d = IDLE;
            end else if (En) begin
               if (timer_q != '0) begin
                  timer_d = timer_q - DIV_W'(1);
               end else begin
                  phase_d = next_phase(phase_q, dir_q);
                  step_d  = 1'b1;
                  rem_d   = rem_q - N'(1);
                  timer_d = period_q - DIV_W'(1);
                  if (rem_q == N'(1)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         phase_q  <= 2'b00;
         timer_q  <= '0;
         period_q <= '0;
         rem_q    <= '0;
         dir_q    <= 1'b0;
         step_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         timer_q  <= timer_d;
         period_q <= period_d;
         rem_q    <= rem_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         done_q   <= done_d;
      end
   end

   assign A         = phase_q[1];
   assign B         = phase_q[0];
   assign Step      = step_q;
   assign Dir       = dir_q;
   assign Busy      = (state_q == RUN);
   assign Done      = done_q;
   assign Remaining = rem_q;

endmodule

// File: tb/tb_quad_step_gen.sv
// Self-checking bench for quad_step_gen: directed scenarios plus random
// commands, compared against an enabled-cycle-count reference model.
module tb_quad_step_gen;
   localparam int N     = 8;
   localparam int DIV_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             Load = 1'b0;
   logic             Din = 1'b0;
   logic [N-1:0]     In = '0;
   logic [DIV_W-1:0] Period = '0;
   logic             En = 1'b0;
   logic             Abort = 1'b0;
   logic             A, B, Step, Dir, Busy, Done;
   logic [N-1:0]     Remaining;

   quad_step_gen #(.N(N), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst_n(rst_n), .Load(Load), .Din(Din), .In(In),
      .Period(Period), .En(En), .Abort(Abort), .A(A), .B(B), .Step(Step),
      .Dir(Dir), .Busy(Busy), .Done(Done), .Remaining(Remaining)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: position 0..3 along the up sequence, and the number of
   // enabled cycles since the command started; a step lands on every P-th one.
   int m_pos, m_ecnt, m_in, m_rem, m_p;
   bit m_busy, m_dir, m_step, m_done;

   int         qcount, done_cnt, step_cnt;
   logic [1:0] prev_ab;

   function automatic logic [1:0] gray(input int p);
      logic [1:0] q;
      q = p[1:0];
      return {q[1], q[1] ^ q[0]};
   endfunction

   function automatic int pidx(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_ecnt = 0; m_in = 0; m_rem = 0; m_p = 1;
      m_busy = 0; m_dir = 0; m_step = 0; m_done = 0;
      prev_ab = 2'b00;
   endtask

   task automatic model_edge();
      m_step = 0;
      m_done = 0;
      if (!m_busy) begin
         if (Load) begin
            if (In != 0) begin
               m_busy = 1; m_in = int'(In); m_rem = int'(In); m_dir = Din;
               m_p = (Period == 0) ? 1 : int'(Period); m_ecnt = 0;
            end else begin
               m_done = 1;
            end
         end
      end else if (Abort) begin
         m_busy = 0; m_rem = 0;
      end else if (En) begin
         m_ecnt++;
         if (m_ecnt % m_p == 0) begin
            m_pos  = (m_pos + (m_dir ? 1 : 3)) % 4;
            m_step = 1;
            m_rem  = m_in - m_ecnt / m_p;
            if (m_rem == 0) begin
               m_busy = 0; m_done = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      logic [1:0] g;
      g = gray(m_pos);
      chk("A", A, g[1]);
      chk("B", B, g[0]);
      chk("Step", Step, m_step);
      chk("Dir", Dir, m_dir);
      chk("Busy", Busy, m_busy);
      chk("Done", Done, m_done);
      chk("Remaining", Remaining, m_rem);
   endtask

   task automatic tick();
      logic [1:0] cur;
      int d;
      @(posedge clk);
      model_edge();
      #1;
      cur = {A, B};
      if (cur !== prev_ab) begin
         chk("ab_onebit", $countones(cur ^ prev_ab), 1);
         d = (pidx(cur) - pidx(prev_ab) + 4) % 4;
         qcount += (d == 1) ? 1 : -1;
      end
      prev_ab = cur;
      if (Done === 1'b1) done_cnt++;
      if (Step === 1'b1) step_cnt++;
      check_all();
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      #3 rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      qcount = 0; done_cnt = 0; step_cnt = 0;
      #12;
      check_all();
      rst_n = 1'b1;

      // Reset asserted in the middle of a run
      Load = 1; In = 10; Din = 1; Period = 2; En = 1;
      tick();
      Load = 0;
      repeat (5) tick();
      async_reset();

      // Up run, P=3
      Load = 1; In = 4; Din = 1; Period = 3;
      tick();
      Load = 0;
      repeat (14) tick();

      // Down run, Period 0 behaves as 1
      Load = 1; In = 2; Din = 0; Period = 0;
      tick();
      Load = 0;
      repeat (4) tick();

      // Zero-length command, then Load ignored while busy
      Load = 1; In = 0; Din = 1;
      tick();
      Load = 0;
      repeat (2) tick();
      step_cnt = 0;
      Load = 1; In = 5; Din = 1; Period = 2;
      tick();
      Load = 0;
      repeat (3) tick();
      Load = 1; In = 7; Din = 0; Period = 1;
      tick();
      Load = 0;
      repeat (12) tick();
      chk("ignored_load_steps", step_cnt, 5);

      // En pause after the 2nd step, Abort after the 4th
      step_cnt = 0;
      Load = 1; In = 6; Din = 1; Period = 2; En = 1;
      tick();
      Load = 0;
      for (int i = 0; i < 20 && step_cnt < 2; i++) tick();
      En = 0;
      repeat (5) tick();
      En = 1;
      for (int i = 0; i < 20 && step_cnt < 4; i++) tick();
      chk("steps_before_abort", step_cnt, 4);
      Abort = 1;
      tick();
      Abort = 0;
      repeat (3) tick();

      // 255 steps into an 8-bit up/down count from PH0
      async_reset();
      qcount = 0; done_cnt = 0;
      Load = 1; In = 255; Din = 1; Period = 1;
      tick();
      Load = 0;
      repeat (257) tick();
      chk("loop_count", qcount & 255, 255);
      chk("loop_done_once", done_cnt, 1);
      chk("loop_final_ab", {A, B}, 2'b10);

      // Random commands, enables, aborts and stray loads
      for (int c = 0; c < 40; c++) begin
         Load = 1; In = N'($urandom_range(0, 12)); Din = 1'($urandom_range(0, 1));
         Period = DIV_W'($urandom_range(0, 3)); En = 1'($urandom_range(0, 1));
         Abort = 1'($urandom_range(0, 1));
         tick();
         for (int i = 0; i < 50; i++) begin
            Load   = ($urandom_range(0, 15) == 0);
            In     = N'($urandom_range(0, 12));
            Din    = 1'($urandom_range(0, 1));
            Period = DIV_W'($urandom_range(0, 3));
            En     = ($urandom_range(0, 3) != 0);
            Abort  = ($urandom_range(0, 40) == 0);
            tick();
         end
      end
      Load = 0; Abort = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/quad_step_gen.md
Name: quad_step_gen

Overview:
- Quadrature step generator: the transmit end of the up/down-count interface.
- Takes a loaded step count, direction and step period, and emits a Gray-coded A/B phase sequence. Each A/B edge is one count for a downstream up/down counter or quadrature decoder.
- Used as the stimulus/driver side of counter subsystems and for stepper-style phase outputs.

Parameters:
N, 8, width of step-count input and Remaining output
DIV_W, 8, width of step-period input (clocks per step)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Load  input  1  start command, sampled on clk
Din  input  1  direction latched at Load: 1 = up, 0 = down
In  input  N  number of steps to emit
Period  input  DIV_W  clocks per step, latched at Load; 0 treated as 1
En  input  1  run enable; 0 pauses the step timer
Abort  input  1  terminate active command
A  output  1  quadrature phase A
B  output  1  quadrature phase B
Step  output  1  one-cycle pulse coincident with each A/B change
Dir  output  1  latched direction of current/last command
Busy  output  1  command in progress
Done  output  1  one-cycle completion pulse
Remaining  output  N  steps still to emit

Behaviour:
- One clock, clk. Reset is asynchronous active-low on rst_n.
- Reset values: A=0, B=0, Step=0, Dir=0, Busy=0, Done=0, Remaining=0; FSM=IDLE; phase=PH0; timer=0.
- Reset asserted mid-command forces these values immediately, independent of clk.
- Phase encoding {A,B}: PH0=00, PH1=01, PH2=11, PH3=10.
  - Up advances PH0>PH1>PH2>PH3>PH0.
  - Down reverses: PH0>PH3>PH2>PH1>PH0.
  - Exactly one of A/B changes per step.
  - Phase is retained across commands; it is never reset by Load, Abort or completion.
- FSM states: IDLE, RUN.
- IDLE, Load=1, In!=0, on edge t:
  - Latch Remaining=In, Dir=Din, period P=max(Period,1).
  - timer=P-1; go to RUN. Busy=1 from t.
- IDLE, Load=1, In==0: stay IDLE; Done=1 for the cycle after t; A/B unchanged.
- RUN, each edge with En=1:
  - If timer!=0: timer decrements.
  - If timer==0: advance phase one step in Dir; Step=1 for that cycle; Remaining-=1; timer=P-1.
- RUN, En=0: timer, phase and Remaining hold. Step=0.
- Last step (Remaining 1>0): on the same edge, go to IDLE, Busy=0, Done=1 for one cycle.
- Timing: with Load accepted at edge t, steps occur at edges t+P, t+2P, ... t+In*P, plus any En=0 cycles. Busy is high for cycles t..t+In*P-1.
- Load while RUN: ignored. Latched values are not updated and there is no restart.
- Abort=1 in RUN: next edge goes to IDLE, Busy=0, Remaining=0, no Done, no Step.
  - Abort has priority over a step due on the same edge.
  - Abort in IDLE has no effect.
  - Abort and Load both asserted in IDLE: Load wins.
- Remaining arithmetic is unsigned N-bit, counting only down, and never wraps below 0.
- Timer is DIV_W bits.

Test Plan:
1. Pulse rst_n low mid-RUN (In=10) -> A=B=0, Busy=0, Remaining=0 immediately, before the next clk edge.
2. From reset: Load In=4, Din=1, Period=3 at edge t -> {A,B}=01,11,10,00 at t+3,t+6,t+9,t+12; 4 Step pulses; Busy high t..t+11; Done one cycle after t+12.
3. Then Load In=2, Din=0, Period=0 -> treated as P=1; {A,B}=10 then 11 on consecutive edges; Dir=0; Remaining 2>1>0.
4. Load In=0 -> Done one cycle, Busy stays 0, A/B unchanged. Load pulsed again during a Busy In=5 run -> ignored; exactly 5 steps.
5. In=6, Period=2, En low for 5 cycles after the 2nd step -> last step delayed by exactly 5 cycles. Abort after the 4th step -> Busy=0, Remaining=0, no Done, A/B frozen at 4th-step phase.
6. Loopback into the team's 8-bit up/down counter: In=255, Din=1, Period=1 from PH0 -> counter advances 255 steps; final phase PH3 (10); Remaining=0; Done once.
